uart_frame_tx: RTL and testbench

- Packetiser that sits directly upstream of uart_tx and feeds it.
- Buffers 16-bit sample words from the acquisition logic.
- Once SAMPLES_PER_FRAME words are buffered, emits one frame byte-by-byte over the uart_tx handshake: sync, length, payload (MSB first), checksum.
- Instantiated in top between the sample source and uart_tx, so the PC side can resynchronise on a fixed header.

---
 rtl/uart_frame_pkg.sv | 39 +++
 rtl/uart_frame_fifo.sv | 73 +++++++
 rtl/uart_frame_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and checksum helper for the uart_frame_tx packetiser.
// Build option: define UART_FRAME_CRC8_EN to use CRC-8 (poly 0x07) as the frame checksum
// instead of the default 8-bit modular sum.
package uart_frame_pkg;

  // Packetiser sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT
  } state_e;

  // Which byte of the frame is being sent.
  typedef enum logic [2:0] {
    F_SYNC,
    F_LEN,
    F_HI,
    F_LO,
    F_CSUM
  } field_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Fold one frame byte into the running checksum.
  function automatic logic [7:0] next_csum(input logic [7:0] acc, input logic [7:0] data);
`ifdef UART_FRAME_CRC8_EN
    logic [7:0] crc;
    crc = acc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      crc = crc[7] ? ((crc << 1) ^ CRC8_POLY) : (crc << 1);
    end
    return crc;
`else
    return acc + data;
`endif
  endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// uart_frame_fifo: single-clock sample buffer with registered occupancy count.
// Pushes while full and pops while empty are ignored.
module uart_frame_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  // Pointer wrap and occupancy bookkeeping; simultaneous push+pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port (contents need no reset).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffers 16-bit samples and emits frames to uart_tx as
// SYNC, LEN, payload bytes (word MSB first), checksum.
// Build option: UART_FRAME_CRC8_EN selects CRC-8 checksum (see uart_frame_pkg).
module uart_frame_tx #(
  parameter int unsigned SAMPLES_PER_FRAME = 4,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        frame_busy,
  output logic        overflow
);

  import uart_frame_pkg::*;

  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  LEN_BYTE    = 8'(2 * SAMPLES_PER_FRAME);
  localparam logic [6:0]  LAST_WORD   = 7'(SAMPLES_PER_FRAME - 1);
  localparam logic [CW-1:0] FRAME_WORDS = CW'(SAMPLES_PER_FRAME);

  state_e      state_q, state_d;
  field_e      field_q, field_d;
  logic [6:0]  word_idx_q, word_idx_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  csum_q, csum_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [15:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          start_ok;

  assign s_ready    = !fifo_full;
  assign fifo_push  = s_valid && s_ready;
  assign start_ok   = (fifo_count >= FRAME_WORDS) && !tx_active;
  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign frame_busy = busy_q;
  assign overflow   = ovf_q;

  uart_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push_i    (fifo_push),
    .wr_data_i (s_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Frame sequencer: next state, byte selection, checksum and status flags.
  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    word_idx_d = word_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    csum_d     = csum_q;
    busy_d     = busy_q;
    fifo_pop   = 1'b0;
    ovf_d      = ovf_q | (s_valid && !s_ready);

    case (state_q)
      IDLE: begin
        csum_d     = '0;
        field_d    = F_SYNC;
        word_idx_d = '0;
        if (start_ok) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        case (field_q)
          F_SYNC: begin
            tx_byte_d = SYNC_BYTE;
            busy_d    = 1'b1;
          end
          F_LEN: begin
            tx_byte_d = LEN_BYTE;
            csum_d    = next_csum(csum_q, LEN_BYTE);
          end
          F_HI: begin
            tx_byte_d = fifo_head[15:8];
            csum_d    = next_csum(csum_q, fifo_head[15:8]);
          end
          F_LO: begin
            tx_byte_d = fifo_head[7:0];
            csum_d    = next_csum(csum_q, fifo_head[7:0]);
          end
          F_CSUM: begin
            tx_byte_d = csum_q;
          end
          default: begin
            tx_byte_d = tx_byte_q;
          end
        endcase
        tx_dv_d = 1'b1;
        state_d = STROBE;
      end

      STROBE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (tx_done) begin
          state_d = LOAD;
          case (field_q)
            F_SYNC: field_d = F_LEN;
            F_LEN:  field_d = F_HI;
            F_HI:   field_d = F_LO;
            F_LO: begin
              fifo_pop = !fifo_empty;
              if (word_idx_q == LAST_WORD) begin
                field_d = F_CSUM;
              end else begin
                word_idx_d = word_idx_q + 7'd1;
                field_d    = F_HI;
              end
            end
            F_CSUM: begin
              // Frame end: does IDLE's clearing inline so a pending frame's SYNC
              // goes out 2 cycles after this tx_done instead of 3.
              busy_d     = 1'b0;
              csum_d     = '0;
              field_d    = F_SYNC;
              word_idx_d = '0;
              if (!start_ok) begin
                state_d = IDLE;
              end
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset abandons any partial frame and drops tx_dv at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      field_q    <= F_SYNC;
      word_idx_q <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      csum_q     <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      word_idx_q <= word_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      csum_q     <= csum_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: self-checking bench for uart_frame_tx with a behavioural uart_tx responder.
`timescale 1ns/1ps
module tb_uart_frame_tx;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic        frame_busy;
  logic        overflow;

  logic        model_active;
  logic        hold_active = 1'b0;
  logic        stall = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          flush_req = 0;

  assign tx_active = model_active | hold_active;

  uart_frame_tx #(
    .SAMPLES_PER_FRAME (N),
    .FIFO_DEPTH        (8),
    .SYNC_BYTE         (8'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .frame_busy (frame_busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder log: one entry per strobed byte.
  logic [7:0] cap_byte[$];
  int         cap_cyc[$];
  int         done_cyc[$];
  logic       fb_after[$];
  int         mon_err = 0;

  logic [15:0] exp_words[$];
  int          rd = 0;
  int          checks = 0;
  int          failures = 0;
  int          last_push_cyc = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endfunction

  // Checksum from first principles: byte sum, or polynomial remainder of message*x^8.
  function automatic logic [7:0] ref_csum(input logic [7:0] b[$]);
`ifdef UART_FRAME_CRC8_EN
    int unsigned rem = 0;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        rem = (rem << 1) | int'(b[i][k]);
        if ((rem & 32'h100) != 0) rem = rem ^ 32'h107;
      end
    end
    for (int k = 0; k < 8; k++) begin
      rem = rem << 1;
      if ((rem & 32'h100) != 0) rem = rem ^ 32'h107;
    end
    return rem[7:0];
`else
    int unsigned sum = 0;
    foreach (b[i]) sum += int'(b[i]);
    return 8'(sum % 256);
`endif
  endfunction

  // Behavioural uart_tx: accepts a strobe, stays active for a random time, pulses done.
  initial begin : uart_model
    int busy;
    bit pend_fb;
    int flush_seen;
    bit prev_dv;
    busy = 0; pend_fb = 0; flush_seen = 0; prev_dv = 0;
    model_active = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_fb) begin
        fb_after[fb_after.size()-1] = frame_busy;
        pend_fb = 0;
      end
      tx_done = 1'b0;
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        busy = 0;
        model_active = 1'b0;
        prev_dv = 0;
      end else begin
        if (tx_dv && prev_dv) mon_err++;
        prev_dv = tx_dv;
        if (busy > 0) begin
          if (tx_byte !== cap_byte[cap_byte.size()-1]) mon_err++;
          if (tx_dv) mon_err++;
          if (!stall) begin
            busy--;
            if (busy == 0) begin
              tx_done = 1'b1;
              model_active = 1'b0;
              done_cyc[done_cyc.size()-1] = cyc;
              pend_fb = 1;
            end
          end
        end else if (tx_dv) begin
          cap_byte.push_back(tx_byte);
          cap_cyc.push_back(cyc);
          done_cyc.push_back(-1);
          fb_after.push_back(1'b0);
          busy = $urandom_range(lat_max, lat_min);
          model_active = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_word(input logic [15:0] w);
    int t = 0;
    while (!s_ready && t < 2000) begin
      step();
      t++;
    end
    if (!s_ready) begin
      fail_now("push_ready_wait");
    end else begin
      s_valid = 1'b1;
      s_data  = w;
      exp_words.push_back(w);
      last_push_cyc = cyc + 1;
      step();
      s_valid = 1'b0;
    end
  endtask

  // Wait for one full frame, then compare bytes, spacing and frame_busy against the model.
  task automatic check_frame(input string tag, input bit chk_sync, input int sync_exp,
                             output logic [7:0] csum_o);
    logic [7:0]  exp_b[$];
    logic [7:0]  body[$];
    logic [15:0] w;
    int t;
    body.push_back(8'(2 * N));
    for (int i = 0; i < int'(N); i++) begin
      w = (exp_words.size() > 0) ? exp_words.pop_front() : 16'h0000;
      body.push_back(w[15:8]);
      body.push_back(w[7:0]);
    end
    exp_b.push_back(8'hA5);
    foreach (body[i]) exp_b.push_back(body[i]);
    exp_b.push_back(ref_csum(body));
    csum_o = 8'h00;
    t = 0;
    while (!(done_cyc.size() >= rd + 11 && done_cyc[rd+10] >= 0) && t < 3000) begin
      step();
      t++;
    end
    if (t >= 3000) begin
      fail_now({tag, "_frame"});
      rd = cap_byte.size();
      return;
    end
    step();
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(cap_byte[rd+i]), 32'(exp_b[i]));
      check($sformatf("%s_busy%0d", tag, i), 32'(fb_after[rd+i]), (i < 10) ? 32'd1 : 32'd0);
      if (i > 0)
        check($sformatf("%s_gap%0d", tag, i), 32'(cap_cyc[rd+i] - done_cyc[rd+i-1]), 32'd2);
    end
    if (chk_sync) check({tag, "_sync_lat"}, 32'(cap_cyc[rd]), 32'(sync_exp));
    csum_o = cap_byte[rd+10];
    rd += 11;
  endtask

  typedef struct {
    logic [3:0][15:0] w;
    logic [7:0]       csum;
    bit               known;
    int               lat;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] cs;
    int t;
    int r;
    int a0;

    vecs[0] = '{w: {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, csum: 8'h40, known: 1, lat: 1};
`ifdef UART_FRAME_CRC8_EN
    vecs[1] = '{w: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, csum: 8'hC1, known: 1, lat: 3};
    vecs[2] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, csum: 8'h00, known: 0, lat: 2};
    vecs[3] = '{w: {16'h0004, 16'h0003, 16'h0002, 16'h0001}, csum: 8'h00, known: 0, lat: 5};
    vecs[0].known = 0;
`else
    vecs[1] = '{w: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, csum: 8'h08, known: 1, lat: 3};
    vecs[2] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, csum: 8'h00, known: 1, lat: 2};
    vecs[3] = '{w: {16'h0004, 16'h0003, 16'h0002, 16'h0001}, csum: 8'h12, known: 1, lat: 5};
`endif

    repeat (3) step();
    check("rst_tx_dv", 32'(tx_dv), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_frame_busy", 32'(frame_busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_s_ready", 32'(s_ready), 1);
    reset_n = 1'b1;
    step();

    // Directed frames from the vector table.
    for (int v = 0; v < 4; v++) begin
      lat_min = vecs[v].lat;
      lat_max = vecs[v].lat;
      for (int j = 0; j < int'(N); j++) push_word(vecs[v].w[j]);
      check_frame($sformatf("vec%0d", v), 1'b1, last_push_cyc + 2, cs);
      if (vecs[v].known) check($sformatf("vec%0d_csum", v), 32'(cs), 32'(vecs[v].csum));
    end

    // Random words, random gaps, random uart_tx latency.
    lat_min = 1;
    lat_max = 6;
    for (int k = 0; k < 3 * int'(N); k++) begin
      push_word(16'($urandom));
      repeat ($urandom_range(3, 0)) step();
    end
    for (int f = 0; f < 3; f++) check_frame($sformatf("rnd%0d", f), 1'b0, 0, cs);

    // tx_active held: no strobe until release, then SYNC 2 cycles later.
    lat_min = 2;
    lat_max = 2;
    hold_active = 1'b1;
    for (int j = 0; j < int'(N); j++) push_word(16'h1000 + 16'(j));
    repeat (10) step();
    check("hold_no_dv", 32'(cap_byte.size()), 32'(rd));
    r = cyc;
    hold_active = 1'b0;
    check_frame("hold", 1'b1, r + 2, cs);

    // Eight continuous words: two back-to-back frames.
    for (int j = 0; j < 2 * int'(N); j++) push_word(16'hB000 + 16'(j * 3));
    a0 = rd;
    check_frame("b2b0", 1'b1, last_push_cyc - 2, cs);
    rd = a0 + 11;
    check_frame("b2b1", 1'b0, 0, cs);
    check("b2b_sync_gap", 32'(cap_cyc[a0+11] - done_cyc[a0+10]), 32'd2);

    // Stalled uart_tx: buffer fills, ninth word overflows and is dropped.
    stall = 1'b1;
    for (int j = 0; j < 8; j++) push_word(16'hC100 + 16'(j));
    check("full_s_ready", 32'(s_ready), 0);
    check("pre_overflow", 32'(overflow), 0);
    s_valid = 1'b1;
    s_data  = 16'hEEEE;
    step();
    s_valid = 1'b0;
    check("overflow_set", 32'(overflow), 1);
    stall = 1'b0;
    check_frame("ovf0", 1'b0, 0, cs);
    check_frame("ovf1", 1'b0, 0, cs);
    check("overflow_sticky", 32'(overflow), 1);
    check("drained_s_ready", 32'(s_ready), 1);

    // Reset while the LO byte of the first word is being strobed.
    for (int j = 0; j < int'(N); j++) push_word(16'hD000 + 16'(j));
    t = 0;
    while (cap_byte.size() < rd + 4 && t < 500) begin
      step();
      t++;
    end
    if (t >= 500) fail_now("reset_wait_lo");
    check("pre_reset_dv", 32'(tx_dv), 1);
    reset_n = 1'b0;
    #1;
    check("reset_tx_dv", 32'(tx_dv), 0);
    check("reset_s_ready", 32'(s_ready), 1);
    check("reset_frame_busy", 32'(frame_busy), 0);
    check("reset_overflow", 32'(overflow), 0);
    flush_req++;
    exp_words.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
    rd = cap_byte.size();
    for (int j = 0; j < int'(N); j++) push_word(16'h5A00 + 16'(j * 17));
    check_frame("post_reset", 1'b1, last_push_cyc + 2, cs);

    repeat (5) step();
    check("monitor_errors", 32'(mon_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
